uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 serial receiver (DIVISOR+1 clocks per bit), byte presented with a one-cycle data_valid strobe.
// Latency: strobe in the cycle after the mid-stop-bit sample edge, t0+2+HALF+9*(DIVISOR+1) (t0+2728 by default).
// Backpressure: none; data holds until the next good frame. Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote.
module uart_rx #(
  parameter int unsigned DIVISOR = 286,
  parameter int unsigned HALF    = (DIVISOR + 1) / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [8:0] DIV_C = 9'(DIVISOR);
  // The counter is cleared on the START entry edge itself, so the HALF-th
  // clock after entry sees HALF-1. Comparing against HALF-1 puts the start
  // sample exactly HALF clocks after entry.
  localparam logic [8:0] START_C = 9'(HALF - 1);

  logic       rx_s1_q, rx_s2_q;
  logic [2:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic       samp;

  // Two-flop synchronizer; idle-high reset so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // History of the two previous synchronized values for the majority vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s2_q};
    end
  end

  assign samp = (rx_s2_q & hist_q[0]) | (rx_s2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rx_s2_q;
`endif

  // Frame FSM: start detect, mid-bit sampling, stop check, break wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s2_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == START_C) begin
          cnt_d = '0;
          if (!samp) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == DIV_C) begin
          cnt_d   = '0;
          shift_d = {samp, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == DIV_C) begin
          cnt_d = '0;
          if (samp) begin
            data_d  = shift_q;
            vld_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_BREAK: begin
        // Hold here until the line idles so a held-low line cannot retrigger
        cnt_d = '0;
        if (rx_s2_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = vld_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames played from a per-cycle rx waveform.
// A frame-level model predicts every output cycle from the waveform; literal pins check the model.
// Runs in either build of UART_RX_MAJORITY_EN; only the glitch expectation differs.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int P    = 287;
  localparam int HALF = 143;
  localparam int WMAX = 16384;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Waveform (value of rx captured at local edge n) and per-observation expectations
  bit         wave  [WMAX];
  bit         e_vld [WMAX];
  bit         e_err [WMAX];
  bit         e_busy[WMAX];
  logic [7:0] e_dat [WMAX];
  int         wlen;
  logic [7:0] model_dat;

  int  checks = 0;
  int  errors = 0;
  bit  obs_on = 1'b0;
  int  obs_n  = 0;
  int  vld_q[$];
  int  vld_dq[$];
  int  err_n;
  int  err_obs;
  int  err_dat;
  int  busy_n;

  function automatic void chk(input string nm, input int obs, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s obs %0d: got %0h want %0h", nm, obs, act, exp);
    end
  endfunction

  task automatic w_put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      wave[wlen] = v;
      wlen++;
    end
  endtask

  task automatic w_frame(input logic [7:0] b, input bit stop, output int t0);
    t0 = wlen;
    w_put(1'b0, P);
    for (int k = 0; k < 8; k++) w_put(b[k], P);
    w_put(stop, P);
  endtask

  function automatic bit wv(input int i);
    if (i < 0 || i >= wlen) return 1'b1;
    return wave[i];
  endfunction

  // Receiver's view of the line at rx-capture edge s (mid-bit point)
  function automatic bit samp(input int s);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(wv(s)) + int'(wv(s - 1)) + int'(wv(s - 2));
    return (ones >= 2);
`else
    return wv(s);
`endif
  endfunction

  function automatic void mark_busy(input int a, input int b);
    for (int n = a; n <= b; n++) begin
      if (n >= 0 && n < wlen) e_busy[n] = 1'b1;
    end
  endfunction

  // Frame-level decode: a falling line at capture edge t0 gives samples at
  // t0+HALF+k*P (k=0 start, 1..8 data, 9 stop); outputs appear two edges later.
  task automatic model_build();
    int t, t0, s, ss, fe, r;
    logic [7:0] b;
    for (int n = 0; n < wlen; n++) begin
      e_vld[n]  = 1'b0;
      e_err[n]  = 1'b0;
      e_busy[n] = 1'b0;
      e_dat[n]  = model_dat;
    end
    t = 0;
    while (t < wlen) begin
      if (wave[t]) begin
        t++;
      end else begin
        t0 = t;
        s  = t0 + HALF;
        if (samp(s)) begin
          mark_busy(t0 + 2, s + 1);
          t = s + 1;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = samp(s + (k + 1) * P);
          ss = s + 9 * P;
          fe = ss + 2;
          if (samp(ss)) begin
            mark_busy(t0 + 2, fe - 1);
            if (fe < wlen) begin
              e_vld[fe] = 1'b1;
              for (int n = fe; n < wlen; n++) e_dat[n] = b;
            end
            t = ss + 1;
          end else begin
            if (fe < wlen) e_err[fe] = 1'b1;
            r = ss + 1;
            while (r < wlen && !wave[r]) r++;
            mark_busy(t0 + 2, r + 1);
            t = r + 1;
          end
        end
      end
    end
  endtask

  task automatic play();
    vld_q.delete();
    vld_dq.delete();
    err_n   = 0;
    err_obs = -1;
    err_dat = -1;
    busy_n  = 0;
    model_build();
    rx = wave[0];
    for (int n = 0; n < wlen; n++) begin
      @(posedge clk);
      obs_n  = n;
      obs_on = 1'b1;
      #1;
      rx = (n + 1 < wlen) ? wave[n + 1] : 1'b1;
    end
    @(negedge clk);
    #1;
    obs_on    = 1'b0;
    model_dat = e_dat[wlen - 1];
  endtask

  // Per-cycle comparison against the model, plus pulse bookkeeping for pins
  always @(negedge clk) begin
    if (obs_on) begin
      chk("data_valid", obs_n, 32'(data_valid), 32'(e_vld[obs_n]));
      chk("frame_err",  obs_n, 32'(frame_err),  32'(e_err[obs_n]));
      chk("busy",       obs_n, 32'(busy),       32'(e_busy[obs_n]));
      chk("data",       obs_n, 32'(data),       32'(e_dat[obs_n]));
      if (data_valid === 1'b1) begin
        vld_q.push_back(obs_n);
        vld_dq.push_back(int'(data));
      end
      if (frame_err === 1'b1) begin
        err_n++;
        err_obs = obs_n;
        err_dat = int'(data);
      end
      if (busy === 1'b1) busy_n++;
    end
  end

  initial begin
    int t0;
    logic [7:0] b96;
    model_dat = 8'h00;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", -1, 32'(data), 32'h0);
    chk("reset_valid", -1, 32'(data_valid), 32'h0);
    chk("reset_ferr", -1, 32'(frame_err), 32'h0);
    chk("reset_busy", -1, 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single frame 0xA5: start at capture edge 10, strobe at 10+2728
    wlen = 0;
    w_put(1'b1, 10);
    w_frame(8'hA5, 1'b1, t0);
    w_put(1'b1, 20);
    play();
    chk("a5_count", -1, vld_q.size(), 1);
    if (vld_q.size() > 0) begin
      chk("a5_time", -1, vld_q[0], 2738);
      chk("a5_data", -1, vld_dq[0], 32'hA5);
    end
    chk("a5_busy_cycles", -1, busy_n, 2726);
    chk("a5_busy_after", -1, 32'(busy), 32'h0);

    // Back-to-back 0x00, 0xFF, 0x55 with one stop bit each
    wlen = 0;
    w_put(1'b1, 10);
    w_frame(8'h00, 1'b1, t0);
    w_frame(8'hFF, 1'b1, t0);
    w_frame(8'h55, 1'b1, t0);
    w_put(1'b1, 20);
    play();
    chk("b2b_count", -1, vld_q.size(), 3);
    if (vld_q.size() == 3) begin
      chk("b2b_gap1", -1, vld_q[1] - vld_q[0], 2870);
      chk("b2b_gap2", -1, vld_q[2] - vld_q[1], 2870);
      chk("b2b_d0", -1, vld_dq[0], 32'h00);
      chk("b2b_d1", -1, vld_dq[1], 32'hFF);
      chk("b2b_d2", -1, vld_dq[2], 32'h55);
    end

    // 50-clock low glitch: START for HALF cycles, then IDLE with no strobes
    wlen = 0;
    w_put(1'b1, 10);
    w_put(1'b0, 50);
    w_put(1'b1, 400);
    play();
    chk("glitch_vld", -1, vld_q.size(), 0);
    chk("glitch_ferr", -1, err_n, 0);
    chk("glitch_busy_cycles", -1, busy_n, 143);
    chk("glitch_data", -1, 32'(data), 32'h55);

    // 0x3C with low stop bit, line held low 5000 more clocks, then 0x81
    wlen = 0;
    w_put(1'b1, 10);
    w_put(1'b0, P);
    for (int k = 0; k < 8; k++) begin
      b96 = 8'h3C;
      w_put(b96[k], P);
    end
    w_put(1'b0, P + 5000);
    w_put(1'b1, 20);
    w_frame(8'h81, 1'b1, t0);
    w_put(1'b1, 20);
    play();
    chk("ferr_count", -1, err_n, 1);
    chk("ferr_time", -1, err_obs, 2738);
    chk("ferr_data_kept", -1, err_dat, 32'h55);
    chk("ferr_vld_count", -1, vld_q.size(), 1);
    if (vld_q.size() > 0) chk("ferr_next_data", -1, vld_dq[0], 32'h81);

    // Reset during data bit 4 of 0x96
    b96  = 8'h96;
    wlen = 0;
    w_put(1'b1, 10);
    w_put(1'b0, P);
    for (int k = 0; k < 4; k++) w_put(b96[k], P);
    w_put(b96[4], 100);
    play();
    chk("midframe_busy", -1, 32'(busy), 32'h1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    chk("midrst_data", -1, 32'(data), 32'h0);
    chk("midrst_valid", -1, 32'(data_valid), 32'h0);
    chk("midrst_ferr", -1, 32'(frame_err), 32'h0);
    chk("midrst_busy", -1, 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_dat = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    wlen = 0;
    w_put(1'b1, 10);
    w_frame(8'h96, 1'b1, t0);
    w_put(1'b1, 20);
    play();
    chk("rst_next_count", -1, vld_q.size(), 1);
    chk("rst_next_data", -1, 32'(data), 32'h96);

    // One-clock high glitch at the bit-2 sample point of 0x00
    wlen = 0;
    w_put(1'b1, 10);
    w_frame(8'h00, 1'b1, t0);
    wave[t0 + HALF + 3 * P] = 1'b1;
    w_put(1'b1, 20);
    play();
    chk("spike_count", -1, vld_q.size(), 1);
    chk("spike_data", -1, 32'(data), 32'(GLITCH_EXP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
